// File: rtl/rgb_pwm_ctrl.sv
// iCE40UP RGB LED driver controller: power-up sequencing, three period-aligned PWM outputs,
// duty updates via valid/ready applied at period boundaries. `RGB_PWM_FADE_EN ramps duties by 1 per period.
module rgb_pwm_ctrl #(
  parameter int CNT_W      = 8,
  parameter int PRESC_W    = 8,
  parameter int WARMUP_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [CNT_W-1:0]   duty0,
  input  logic [CNT_W-1:0]   duty1,
  input  logic [CNT_W-1:0]   duty2,
  output logic               rgb_leden,
  output logic               rgb_pu,
  output logic               rgb0_pwm,
  output logic               rgb1_pwm,
  output logic               rgb2_pwm,
  output logic               period_start,
  output logic               running
);

  localparam logic [CNT_W-1:0] LAST_CNT = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam int WARM_W = $clog2(WARMUP_CYC + 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYC - 1);

  typedef enum logic [1:0] {S_OFF, S_WARMUP, S_RUN} state_t;

  state_t                  state, state_nxt;
  logic [WARM_W-1:0]       warm;
  logic [PRESC_W-1:0]      pcnt;
  logic [CNT_W-1:0]        cnt;
  logic [2:0][CNT_W-1:0]   shadow, shadow_nxt;
  logic [2:0][CNT_W-1:0]   active, active_nxt;
  logic                    pending, pending_nxt;
  logic [2:0]              pwm_nxt;
  logic                    tick, boundary, accept, warm_done;

  assign tick      = (pcnt >= presc);
  assign boundary  = (state == S_RUN) && tick && (cnt == LAST_CNT);
  assign accept    = upd_valid && !pending;
  assign warm_done = (warm == WARM_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_OFF:    if (en) state_nxt = S_WARMUP;
      S_WARMUP: if (!en) state_nxt = S_OFF;
                else if (warm_done) state_nxt = S_RUN;
      S_RUN:    if (!en) state_nxt = S_OFF;
      default:  state_nxt = S_OFF;
    endcase
  end

  // Accept and boundary never coincide: ready is low whenever something is pending.
  always_comb begin
    shadow_nxt  = shadow;
    active_nxt  = active;
    pending_nxt = pending;
    if (accept) begin
      shadow_nxt  = {duty2, duty1, duty0};
      pending_nxt = 1'b1;
    end else if (pending && state != S_RUN) begin
      active_nxt  = shadow;
      pending_nxt = 1'b0;
    end else if (pending && boundary) begin
`ifdef RGB_PWM_FADE_EN
      for (int i = 0; i < 3; i++) begin
        if (active[i] < shadow[i])
          active_nxt[i] = active[i] + 1'b1;
        else if (active[i] > shadow[i])
          active_nxt[i] = active[i] - 1'b1;
      end
      pending_nxt = (active_nxt != shadow);
`else
      active_nxt  = shadow;
      pending_nxt = 1'b0;
`endif
    end
  end

  always_comb begin
    pwm_nxt = 3'b000;
    for (int i = 0; i < 3; i++)
      pwm_nxt[i] = (state == S_RUN) && en && (cnt < active[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_OFF;
      warm         <= '0;
      pcnt         <= '0;
      cnt          <= '0;
      shadow       <= '0;
      active       <= '0;
      pending      <= 1'b0;
      upd_ready    <= 1'b1;
      rgb_leden    <= 1'b0;
      rgb_pu       <= 1'b0;
      rgb0_pwm     <= 1'b0;
      rgb1_pwm     <= 1'b0;
      rgb2_pwm     <= 1'b0;
      period_start <= 1'b0;
      running      <= 1'b0;
    end else begin
      state   <= state_nxt;
      warm    <= (state == S_WARMUP) ? warm + 1'b1 : '0;
      shadow  <= shadow_nxt;
      active  <= active_nxt;
      pending <= pending_nxt;
      if (state == S_RUN && en) begin
        pcnt <= tick ? '0 : pcnt + 1'b1;
        if (tick)
          cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
      end else begin
        pcnt <= '0;
        cnt  <= '0;
      end
      upd_ready    <= !pending_nxt;
      rgb_leden    <= (state_nxt != S_OFF);
      rgb_pu       <= (state_nxt != S_OFF);
      running      <= (state_nxt == S_RUN);
      rgb0_pwm     <= pwm_nxt[0];
      rgb1_pwm     <= pwm_nxt[1];
      rgb2_pwm     <= pwm_nxt[2];
      period_start <= (state == S_WARMUP && state_nxt == S_RUN) || (boundary && en);
    end
  end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Bench for rgb_pwm_ctrl: per-period PWM high counts checked by a window monitor against a queue
// of expectations; sequencing, handshake and reset checked inline.
module tb_rgb_pwm_ctrl;
  localparam int CNT_W = 8;
  localparam int PRESC_W = 8;
  localparam int WCYC = 16;
  localparam int MAXC = 255;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, upd_valid = 1'b0;
  logic [PRESC_W-1:0] presc = '0;
  logic [CNT_W-1:0] duty0 = '0, duty1 = '0, duty2 = '0;
  logic upd_ready, rgb_leden, rgb_pu, rgb0_pwm, rgb1_pwm, rgb2_pwm, period_start, running;

  always #5 clk = ~clk;

  rgb_pwm_ctrl #(.CNT_W(CNT_W), .PRESC_W(PRESC_W), .WARMUP_CYC(WCYC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .presc(presc),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .duty0(duty0), .duty1(duty1), .duty2(duty2),
    .rgb_leden(rgb_leden), .rgb_pu(rgb_pu),
    .rgb0_pwm(rgb0_pwm), .rgb1_pwm(rgb1_pwm), .rgb2_pwm(rgb2_pwm),
    .period_start(period_start), .running(running)
  );

  typedef struct { int h0; int h1; int h2; int len; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // A window spans the samples one clk after each period_start, i.e. the pwm of cnt 0..MAXC-1.
  int mh0, mh1, mh2, mlen;
  bit started = 1'b0, ps_prev = 1'b0;
  always @(negedge clk) begin
    if (!running) begin
      started = 1'b0; ps_prev = 1'b0;
      mh0 = 0; mh1 = 0; mh2 = 0; mlen = 0;
    end else begin
      if (ps_prev) begin
        if (started && q.size() > 0) begin
          mon_e = q.pop_front();
          chk("win_high0", mh0, mon_e.h0);
          chk("win_high1", mh1, mon_e.h1);
          chk("win_high2", mh2, mon_e.h2);
          chk("win_len", mlen, mon_e.len);
        end
        started = 1'b1;
        mh0 = 0; mh1 = 0; mh2 = 0; mlen = 0;
      end
      mlen++;
      mh0 += int'(rgb0_pwm); mh1 += int'(rgb1_pwm); mh2 += int'(rgb2_pwm);
      ps_prev = period_start;
    end
  end

  task automatic push(input int h0, input int h1, input int h2, input int len);
    exp_t e;
    e.h0 = h0; e.h1 = h1; e.h2 = h2; e.len = len;
    q.push_back(e);
  endtask

  task automatic send(input int d0, input int d1, input int d2, output int waited);
    @(negedge clk);
    upd_valid = 1'b1;
    duty0 = CNT_W'(d0); duty1 = CNT_W'(d1); duty2 = CNT_W'(d2);
    waited = 0;
    while (!upd_ready && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 4000) chk("send_timeout", 0, 1);
    @(negedge clk);
    upd_valid = 1'b0;
    chk("ready_drop_after_accept", int'(upd_ready), 0);
  endtask

  task automatic sync_period();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 3000);
    if (n >= 3000) chk("sync_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_remaining", q.size(), 0);
  endtask

  task automatic warmup_run(input bit exp0);
    bit ok_on = 1'b1, ok_idle = 1'b1;
    @(negedge clk);
    en = 1'b1;
    for (int k = 1; k <= WCYC; k++) begin
      @(negedge clk);
      if (!(rgb_leden && rgb_pu)) ok_on = 1'b0;
      if (running || rgb0_pwm || rgb1_pwm || rgb2_pwm || period_start) ok_idle = 1'b0;
    end
    chk("warmup_enables", int'(ok_on), 1);
    chk("warmup_idle", int'(ok_idle), 1);
    @(negedge clk);
    chk("run_entry", int'({running, period_start, rgb0_pwm, rgb1_pwm, rgb2_pwm}), int'(5'b11000));
    @(negedge clk);
    chk("first_pwm", int'({period_start, rgb0_pwm, rgb1_pwm, rgb2_pwm}), int'({1'b0, exp0, 2'b01}));
  endtask

  int w, cur_d0;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        int'({rgb_leden, rgb_pu, rgb0_pwm, rgb1_pwm, rgb2_pwm, period_start, running, upd_ready}), 1);
    rst_n = 1'b1;

    // Load duties in OFF, then power up.
    send(64, 0, 255, w);
    warmup_run(1'b1);
    sync_period();
    push(64, 0, 255, MAXC);
    push(64, 0, 255, MAXC);
    wait_drain(700);

`ifndef RGB_PWM_FADE_EN
    presc = 8'd3;
    send(10, 0, 255, w);
    sync_period();
    push(40, 0, 1020, 1020);
    wait_drain(1200);

    presc = 8'd0;
    send(64, 0, 255, w);
    sync_period();
    repeat (100) @(negedge clk);
    send(128, 0, 255, w);
    push(64, 0, 255, MAXC);
    push(128, 0, 255, MAXC);
    send(32, 0, 255, w);
    chk("held_until_boundary", int'(w > 100), 1);
    push(32, 0, 255, MAXC);
    wait_drain(900);
    cur_d0 = 32;
`else
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    send(10, 0, 255, w);
    repeat (2) @(negedge clk);
    warmup_run(1'b1);
    sync_period();
    send(13, 0, 255, w);
    push(10, 0, 255, MAXC);
    push(11, 0, 255, MAXC);
    push(12, 0, 255, MAXC);
    push(13, 0, 255, MAXC);
    w = 0;
    while (!upd_ready && w < 1200) begin
      @(negedge clk);
      w++;
    end
    chk("fade_ready_at_third_boundary", int'(w > 700 && w < 800), 1);
    wait_drain(1200);
    cur_d0 = 13;
`endif

    // en dropped during a high pulse: everything off on the next clk.
    sync_period();
    repeat (5) @(negedge clk);
    chk("mid_high_pulse", int'(rgb0_pwm), 1);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_outputs", int'({rgb_leden, rgb_pu, rgb0_pwm, rgb1_pwm, rgb2_pwm, running}), 0);
    repeat (3) @(negedge clk);
    warmup_run(1'b1);
    sync_period();
    push(cur_d0, 0, 255, MAXC);
    wait_drain(700);

    // Asynchronous reset between clock edges.
    sync_period();
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs",
           int'({rgb_leden, rgb_pu, rgb0_pwm, rgb1_pwm, rgb2_pwm, period_start, running, upd_ready}), 1);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", int'({rgb_leden, running, upd_ready}), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
